// File: rtl/fp32_mult_core.sv
// Iterative IEEE-754 single-precision multiplier core: 24-cycle shift-add significand
// multiply, then normalize and round; raw result plus flags for the exception stage.
package fp32_mult_pkg;
   typedef enum logic [2:0] {
      IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero
   } round_values;
endpackage

module fp32_mult_core
   import fp32_mult_pkg::*;
#(
   parameter round_values round = IEEE_near
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] z_calc,
   output logic        overflow,
   output logic        underflow,
   output logic        inexact
);

   typedef enum logic [2:0] {S_IDLE, S_MULT, S_NORM, S_ROUND, S_DONE} state_t;

   state_t             r_state;
   logic               r_sign;
   logic               r_special;
   logic signed [9:0]  r_exp;
   logic [23:0]        r_ma;
   logic [23:0]        r_mb;
   logic [47:0]        r_acc;
   logic [4:0]         r_cnt;
   logic [22:0]        r_frac;
   logic               r_guard;
   logic               r_sticky;

   logic               w_inc;
   logic [23:0]        w_frac_inc;
   logic [22:0]        w_frac_rnd;
   logic signed [9:0]  w_exp_rnd;

   function automatic logic f_round_inc(input logic sign, input logic guard,
                                        input logic sticky, input logic lsb);
      logic inc;
      case (round)
         IEEE_near: inc = guard & (sticky | lsb);
         IEEE_zero: inc = 1'b0;
         IEEE_pinf: inc = ~sign & (guard | sticky);
         IEEE_ninf: inc = sign & (guard | sticky);
         near_up:   inc = guard;
         away_zero: inc = guard | sticky;
         default:   inc = 1'b0;
      endcase
      return inc;
   endfunction

   assign in_ready = (r_state == S_IDLE);

   // Rounding increment; a carry past bit 22 renormalizes into the exponent.
   always_comb begin
      w_inc      = f_round_inc(r_sign, r_guard, r_sticky, r_frac[0]);
      w_frac_inc = {1'b0, r_frac} + {23'b0, w_inc};
      w_frac_rnd = w_frac_inc[23] ? 23'b0 : w_frac_inc[22:0];
      w_exp_rnd  = w_frac_inc[23] ? r_exp + 10'sd1 : r_exp;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= S_IDLE;
         r_cnt     <= 5'd0;
         out_valid <= 1'b0;
         z_calc    <= 32'b0;
         overflow  <= 1'b0;
         underflow <= 1'b0;
         inexact   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_sign    <= a[31] ^ b[31];
                  r_exp     <= $signed({2'b00, a[30:23]} + {2'b00, b[30:23]} - 10'd127);
                  r_ma      <= {1'b1, a[22:0]};
                  r_mb      <= {1'b1, b[22:0]};
                  r_acc     <= 48'b0;
                  r_cnt     <= 5'd0;
                  r_special <= (a[30:23] == 8'h00) || (a[30:23] == 8'hFF) ||
                               (b[30:23] == 8'h00) || (b[30:23] == 8'hFF);
                  r_state   <= S_MULT;
               end
            end
            S_MULT: begin
               if (r_mb[r_cnt])
                  r_acc <= r_acc + ({24'b0, r_ma} << r_cnt);
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd23)
                  r_state <= S_NORM;
            end
            S_NORM: begin
               if (r_acc[47]) begin
                  r_frac   <= r_acc[46:24];
                  r_guard  <= r_acc[23];
                  r_sticky <= |r_acc[22:0];
                  r_exp    <= r_exp + 10'sd1;
               end else begin
                  r_frac   <= r_acc[45:23];
                  r_guard  <= r_acc[22];
                  r_sticky <= |r_acc[21:0];
               end
               r_state <= S_ROUND;
            end
            S_ROUND: begin
               if (r_special) begin
                  z_calc    <= {r_sign, 31'b0};
                  overflow  <= 1'b0;
                  underflow <= 1'b0;
                  inexact   <= 1'b0;
               end else begin
                  z_calc    <= {r_sign, w_exp_rnd[7:0], w_frac_rnd};
                  overflow  <= (w_exp_rnd > 10'sd254);
                  underflow <= (w_exp_rnd < 10'sd1);
                  inexact   <= r_guard | r_sticky;
               end
               out_valid <= 1'b1;
               r_state   <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  r_state   <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp32_mult_core.sv
// Bench for fp32_mult_core: one instance per rounding mode, all fed the same operands,
// checked against an integer-arithmetic reference model.
module tb_fp32_mult_core;
   import fp32_mult_pkg::*;

   localparam int N = 6;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        out_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        in_ready  [N];
   logic        out_valid [N];
   logic [31:0] z_calc    [N];
   logic        overflow  [N];
   logic        underflow [N];
   logic        inexact   [N];

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      fp32_mult_core #(.round(round_values'(g))) u_dut (
         .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready[g]),
         .a(a), .b(b), .out_valid(out_valid[g]), .out_ready(out_ready),
         .z_calc(z_calc[g]), .overflow(overflow[g]), .underflow(underflow[g]),
         .inexact(inexact[g])
      );
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Reference: exact 48-bit product, then round using the remainder below the kept bits.
   function automatic void model(input logic [31:0] x, input logic [31:0] y, input int mode,
                                 output logic [31:0] z, output logic ov, output logic un,
                                 output logic ix, output logic sp);
      longint unsigned ma   = {40'd0, 1'b1, x[22:0]};
      longint unsigned mb   = {40'd0, 1'b1, y[22:0]};
      longint unsigned prod = ma * mb;
      longint unsigned q, rem, half;
      int              e = int'(x[30:23]) + int'(y[30:23]) - 127;
      int              s = 23;
      logic            sg = x[31] ^ y[31];
      logic            gd, st, inc;
      logic [31:0]     ev;
      if (prod >= (64'd1 << 47)) begin
         s = 24;
         e++;
      end
      q    = prod >> s;
      rem  = prod - (q << s);
      half = 64'd1 << (s - 1);
      gd   = (rem >= half);
      st   = ((rem % half) != 0);
      case (mode)
         0:       inc = gd && (st || q[0]);
         1:       inc = 1'b0;
         2:       inc = !sg && (gd || st);
         3:       inc = sg && (gd || st);
         4:       inc = gd;
         default: inc = gd || st;
      endcase
      q = q + {63'd0, inc};
      if (q == (64'd1 << 24)) begin
         q = 64'd1 << 23;
         e++;
      end
      ev = e;
      z  = {sg, ev[7:0], q[22:0]};
      ov = (e > 254);
      un = (e < 1);
      ix = gd || st;
      sp = (x[30:23] == 8'h00) || (x[30:23] == 8'hFF) ||
           (y[30:23] == 8'h00) || (y[30:23] == 8'hFF);
   endfunction

   task automatic check_all(input logic [31:0] x, input logic [31:0] y);
      logic [31:0] ez;
      logic        eo, eu, ei, sp;
      for (int d = 0; d < N; d++) begin
         model(x, y, d, ez, eo, eu, ei, sp);
         if (sp) begin
            chk($sformatf("sign_m%0d", d), {31'd0, z_calc[d][31]}, {31'd0, ez[31]});
         end else begin
            chk($sformatf("z_m%0d", d), z_calc[d], ez);
         end
         chk($sformatf("ovf_m%0d", d), {31'd0, overflow[d]},  {31'd0, eo && !sp});
         chk($sformatf("unf_m%0d", d), {31'd0, underflow[d]}, {31'd0, eu && !sp});
         chk($sformatf("inx_m%0d", d), {31'd0, inexact[d]},   {31'd0, ei && !sp});
      end
   endtask

   // Accept one operand pair, scramble the inputs afterwards, and wait for out_valid.
   task automatic run_op(input logic [31:0] x, input logic [31:0] y);
      int lat;
      a = x;
      b = y;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      a = $urandom;
      b = $urandom;
      lat = 0;
      while (!out_valid[0] && lat < 60) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      chk("latency", lat, 26);
      for (int d = 0; d < N; d++)
         chk($sformatf("valid_m%0d", d), {31'd0, out_valid[d]}, 32'd1);
      check_all(x, y);
   endtask

   task automatic release_op();
      out_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      chk("drop_valid", {31'd0, out_valid[0]}, 32'd0);
      chk("back_ready", {31'd0, in_ready[0]}, 32'd1);
   endtask

   initial begin
      logic [31:0] hz;
      logic [2:0]  hf;
      logic [31:0] ra, rb;
      rst = 1'b1;
      in_valid = 1'b0;
      out_ready = 1'b1;
      a = 32'd0;
      b = 32'd0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      for (int d = 0; d < N; d++) begin
         chk("rst_ready", {31'd0, in_ready[d]}, 32'd1);
         chk("rst_valid", {31'd0, out_valid[d]}, 32'd0);
         chk("rst_z", z_calc[d], 32'd0);
         chk("rst_flags", {29'd0, overflow[d], underflow[d], inexact[d]}, 32'd0);
      end

      run_op(32'h3FC00000, 32'h40000000);
      chk("dir_1p5x2", z_calc[0], 32'h40400000);
      release_op();

      run_op(32'h3F800001, 32'h3F800001);
      chk("dir_near", z_calc[0], 32'h3F800002);
      chk("dir_near_inx", {31'd0, inexact[0]}, 32'd1);
      chk("dir_pinf", z_calc[2], 32'h3F800003);
      release_op();

      run_op(32'hBF800001, 32'h3F800001);
      chk("dir_pinf_neg", z_calc[2], 32'hBF800002);
      release_op();

      run_op(32'h7F000000, 32'h7F000000);
      chk("dir_ovf", {30'd0, overflow[0], underflow[0]}, 32'd2);
      release_op();

      run_op(32'h00800000, 32'h00800000);
      chk("dir_unf", {30'd0, overflow[0], underflow[0]}, 32'd1);
      release_op();

      run_op(32'h00000000, 32'h7F800000);
      chk("dir_special", {z_calc[0][31], overflow[0], underflow[0], inexact[0]}, 32'd0);
      release_op();

      // Backpressure: result must hold while the consumer stalls.
      out_ready = 1'b0;
      ra = $urandom;
      rb = {2'b00, 1'b1, 29'(ra)} ^ 32'h1F000000;
      run_op(32'h40490FDB, rb);
      hz = z_calc[0];
      hf = {overflow[0], underflow[0], inexact[0]};
      repeat (10) begin
         @(posedge clk);
         @(negedge clk);
         chk("bp_valid", {31'd0, out_valid[0]}, 32'd1);
         chk("bp_ready", {31'd0, in_ready[0]}, 32'd0);
         chk("bp_z", z_calc[0], hz);
         chk("bp_flags", {29'd0, overflow[0], underflow[0], inexact[0]}, {29'd0, hf});
      end
      release_op();

      // Reset mid-multiply at counter 10, then a clean transaction.
      a = 32'h7F7FFFFF;
      b = 32'h7F7FFFFF;
      in_valid = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      repeat (10) @(posedge clk);
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      chk("abort_ready", {31'd0, in_ready[0]}, 32'd1);
      chk("abort_valid", {31'd0, out_valid[0]}, 32'd0);
      repeat (30) @(posedge clk);
      @(negedge clk);
      chk("abort_silent", {31'd0, out_valid[0]}, 32'd0);
      run_op(32'h3FC00000, 32'h3FC00000);
      chk("after_abort", z_calc[0], 32'h40100000);
      release_op();

      for (int i = 0; i < 25; i++) begin
         ra = $urandom;
         rb = $urandom;
         run_op(ra, rb);
         release_op();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp32_mult_core.md
Name: fp32_mult_core

Overview:
- Iterative IEEE-754 single-precision multiplier datapath. Produces the raw packed result plus overflow, underflow and inexact indications consumed by the downstream multiplier exception stage.
- Accepts one operand pair per transaction over a valid/ready handshake.
- Runs a 24-cycle radix-2 shift-add significand multiply, then normalizes and rounds per the shared round_values parameter.
- Holds the result until the consumer accepts it.

Parameters:
- round, IEEE_near, rounding mode of type round_values {IEEE_near, IEEE_zero, IEEE_pinf, IEEE_ninf, near_up, away_zero}; must match the exception stage instance.

Ports:
- clk  in  1  single clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair a/b valid.
- in_ready  out  1  core can accept operands.
- a  in  32  IEEE-754 operand.
- b  in  32  IEEE-754 operand.
- out_valid  out  1  z_calc and flags valid.
- out_ready  in  1  consumer accepts result.
- z_calc  out  32  {sign, exp[7:0], frac[22:0]} computed result.
- overflow  out  1  rounded biased exponent > 254.
- underflow  out  1  rounded biased exponent < 1.
- inexact  out  1  guard or sticky bit nonzero before rounding.

Behaviour:
- Reset (rst=1 at edge): state=IDLE; in_ready=1 (combinational from IDLE); out_valid=0; z_calc=0; overflow=underflow=inexact=0; counter=0. Reset in any state aborts the in-flight operation silently; no output is produced for it.
- FSM states: IDLE -> MULT -> NORM -> ROUND -> DONE -> IDLE.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready: latch sign=a[31]^b[31], exp_sum=a[30:23]+b[30:23]-127 (10-bit signed), ma={1,a[22:0]}, mb={1,b[22:0]}, acc=48'b0, counter=0.
  - Latch special = (a or b exponent is 0 or 255).
  - Go to MULT.
- MULT:
  - Each cycle: if mb[counter], acc += ma<<counter; counter++.
  - After counter==23 is processed (24 cycles), go to NORM.
- NORM:
  - If acc[47]: frac=acc[46:24], guard=acc[23], sticky=|acc[22:0], exp=exp_sum+1.
  - Else: frac=acc[45:23], guard=acc[22], sticky=|acc[21:0], exp=exp_sum.
  - Go to ROUND.
- ROUND:
  - inc rule per mode:
    - IEEE_near: guard&(sticky|frac[0]).
    - IEEE_zero: 0.
    - IEEE_pinf: ~sign&(guard|sticky).
    - IEEE_ninf: sign&(guard|sticky).
    - near_up: guard.
    - away_zero: guard|sticky.
  - frac+inc carries out of bit 22: frac=0, exp+=1.
  - overflow=(exp>254); underflow=(exp<1) (signed compare on 10-bit exp); inexact=guard|sticky.
  - z_calc={sign, exp[7:0], frac}.
  - If special: overflow=underflow=inexact=0; z_calc[31]=sign still valid; rest don't-care.
  - Go to DONE.
- DONE:
  - out_valid=1; z_calc/flags stable.
  - On out_ready: out_valid=0 next cycle, go to IDLE.
  - out_valid stays high indefinitely while out_ready=0.
- Latency:
  - Acceptance edge to out_valid=1 is exactly 26 rising edges, independent of data or special operands.
  - Throughput: one operation per 28 cycles minimum (IDLE + 26 + DONE).
- in_ready=0 in all states except IDLE; in_valid outside IDLE is ignored and not queued.
- Operand inputs are sampled only at the acceptance edge; changes afterwards have no effect.

Test Plan:
1. a=0x3FC00000, b=0x40000000, round=IEEE_near, out_ready=1 -> out_valid exactly 26 edges after accept; z_calc=0x40400000, overflow=underflow=inexact=0.
2. a=0x3F800001, b=0x3F800001 -> IEEE_near: z_calc=0x3F800002, inexact=1. IEEE_pinf: z_calc=0x3F800003. Same with a=0xBF800001 under IEEE_pinf: z_calc=0xBF800002.
3. a=0x7F000000, b=0x7F000000 -> overflow=1, underflow=0. a=0x00800000, b=0x00800000 -> underflow=1, overflow=0.
4. a=0x00000000, b=0x7F800000 (special) -> flags all 0; z_calc[31]=0; latency still 26.
5. Backpressure: hold out_ready=0 for 10 cycles after out_valid -> z_calc/flags stable, in_ready=0; out_ready=1 -> out_valid drops next edge, in_ready=1.
6. Assert rst for one edge while counter=10 in MULT -> next cycle IDLE, in_ready=1, out_valid=0. A new transaction then completes correctly with no residue from the aborted one.
